// File: rtl/vga_board_write_scheduler_if.sv
// Requester write ports and board RAM write port of the VGA board write scheduler.
// The scheduler takes the slave side; requesters and the RAM sit on the master side.
interface vga_board_write_scheduler_if #(
  parameter int COLOR_W = 3
);
  logic               req0_valid;
  logic [2:0]         req0_row;
  logic [2:0]         req0_col;
  logic [COLOR_W-1:0] req0_color;
  logic               req0_ready;

  logic               req1_valid;
  logic [2:0]         req1_row;
  logic [2:0]         req1_col;
  logic [COLOR_W-1:0] req1_color;
  logic               req1_ready;

  logic               bram_we;
  logic [5:0]         bram_addr;
  logic [COLOR_W-1:0] bram_wdata;

  modport master (
    output req0_valid, req0_row, req0_col, req0_color,
    input  req0_ready,
    output req1_valid, req1_row, req1_col, req1_color,
    input  req1_ready,
    input  bram_we, bram_addr, bram_wdata
  );

  modport slave (
    input  req0_valid, req0_row, req0_col, req0_color,
    output req0_ready,
    input  req1_valid, req1_row, req1_col, req1_color,
    output req1_ready,
    output bram_we, bram_addr, bram_wdata
  );
endinterface

// File: rtl/vga_board_write_scheduler.sv
// Arbitrates two requesters into a small write FIFO and commits the queued cell writes,
// plus any pending full-board clear, to the board RAM only during vertical blanking.
module vga_board_write_scheduler #(
  parameter int V_ACTIVE_START = 35,
  parameter int V_ACTIVE_END   = 515,
  parameter int FIFO_DEPTH     = 4,
  parameter int COLOR_W        = 3
) (
  input  logic                            clk_25MHz,
  input  logic                            rst,
  input  logic [9:0]                      h_counter,
  input  logic [9:0]                      v_counter,
  input  logic                            clear_req,
  output logic                            frame_tick,
  output logic                            busy,
  vga_board_write_scheduler_if.slave      bus
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = 6 + COLOR_W;

  typedef enum logic [1:0] {IDLE, COMMIT, CLEAR} state_t;

  state_t               state;
  state_t               state_next;
  logic [ENTRY_W-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W:0]       count;
  logic                 clear_pend;
  logic [5:0]           clear_addr;
  logic                 rr;
  logic                 vblank;
  logic                 full;
  logic                 empty;
  logic                 grant0;
  logic                 grant1;
  logic                 push;
  logic                 pop;
  logic                 clear_done;
  logic [ENTRY_W-1:0]   push_entry;
  logic [ENTRY_W-1:0]   head;

  assign vblank = (v_counter < 10'(V_ACTIVE_START)) || (v_counter >= 10'(V_ACTIVE_END));
  assign full   = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign empty  = (count == '0);
  assign head   = fifo_mem[rd_ptr];
  assign busy   = !empty || clear_pend;

  // rr=0 prefers req0 on a contested cycle; ready is also held low while reset is asserted
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst && !full) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant0 = !rr;
        grant1 = rr;
      end else begin
        grant0 = bus.req0_valid;
        grant1 = bus.req1_valid;
      end
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign push           = grant0 || grant1;
  assign push_entry     = grant0 ? {bus.req0_row, bus.req0_col, bus.req0_color}
                                 : {bus.req1_row, bus.req1_col, bus.req1_color};
  assign clear_done     = (state == CLEAR) && vblank && (clear_addr == 6'd63);

  always_comb begin
    state_next     = state;
    pop            = 1'b0;
    bus.bram_we    = 1'b0;
    bus.bram_addr  = 6'd0;
    bus.bram_wdata = '0;
    unique case (state)
      IDLE: begin
        if (clear_pend && vblank) begin
          state_next = CLEAR;
        end else if (!empty && vblank) begin
          state_next = COMMIT;
        end
      end
      COMMIT: begin
        bus.bram_addr  = head[ENTRY_W-1 -: 6];
        bus.bram_wdata = head[COLOR_W-1:0];
        if (vblank && !empty) begin
          pop         = 1'b1;
          bus.bram_we = 1'b1;
        end
        if (!vblank || clear_pend || empty || (count == (PTR_W+1)'(1) && !push)) begin
          state_next = IDLE;
        end
      end
      CLEAR: begin
        bus.bram_addr = clear_addr;
        bus.bram_we   = vblank;
        if (clear_done) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_25MHz) begin
    if (push) begin
      fifo_mem[wr_ptr] <= push_entry;
    end
  end

  always_ff @(posedge clk_25MHz) begin
    if (!rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      clear_pend <= 1'b0;
      clear_addr <= 6'd0;
      rr         <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_next;
      frame_tick <= (h_counter == 10'd0) && (v_counter == 10'd0);
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
      if (grant0 && bus.req1_valid) begin
        rr <= 1'b1;
      end else if (grant1 && bus.req0_valid) begin
        rr <= 1'b0;
      end
      // the address wraps 63->0 on the final write, leaving it ready for the next clear
      if ((state == CLEAR) && vblank) begin
        clear_addr <= clear_addr + 6'd1;
      end
      if (clear_done) begin
        clear_pend <= 1'b0;
      end else if (clear_req) begin
        clear_pend <= 1'b1;
      end
    end
  end

endmodule
